// File: rtl/hazard_pkg.sv
// Shared types for the hazard unit: forward-select codes, FSM states
// and the hard-wired zero register index.
package hazard_pkg;

    typedef enum logic [1:0] {
        FWD_RF = 2'b00,
        FWD_W  = 2'b01,
        FWD_M  = 2'b10
    } fwd_sel_t;

    typedef enum logic {
        RUN      = 1'b0,
        LU_STALL = 1'b1
    } hz_state_t;

    localparam int unsigned REG_X0 = 0;

endpackage

// File: rtl/fwd_select.sv
// Single-operand forwarding priority encoder: M beats W, x0 never forwards.
module fwd_select
    import hazard_pkg::*;
#(
    parameter int REG_AW = 5
) (
    input  logic [REG_AW-1:0] rs_i,
    input  logic [REG_AW-1:0] rd_m_i,
    input  logic              reg_write_m_i,
    input  logic [REG_AW-1:0] rd_w_i,
    input  logic              reg_write_w_i,
    output fwd_sel_t          sel_o
);

    logic hit_m;
    logic hit_w;

    assign hit_m = reg_write_m_i
                && (rd_m_i != REG_AW'(REG_X0))
                && (rd_m_i == rs_i);
    assign hit_w = reg_write_w_i
                && (rd_w_i != REG_AW'(REG_X0))
                && (rd_w_i == rs_i);

    always_comb begin
        sel_o = FWD_RF;
        if (hit_m) begin
            sel_o = FWD_M;
        end else if (hit_w) begin
            sel_o = FWD_W;
        end
    end

endmodule

// File: rtl/hazard_unit_v2.sv
// 5-stage pipeline hazard unit: forwarding, load-use stall FSM, branch flush,
// dmem-busy freeze. Define HAZARD_PERF_EN to add stall/flush perf counters.
module hazard_unit_v2
    import hazard_pkg::*;
#(
    parameter int REG_AW   = 5,
    parameter int NUM_SRC  = 2,
    parameter int LOAD_LAT = 1
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic [NUM_SRC*REG_AW-1:0] rs_d_i,
    input  logic [NUM_SRC*REG_AW-1:0] rs_e_i,
    input  logic [REG_AW-1:0]         rd_e_i,
    input  logic                      mem_read_e_i,
    input  logic [REG_AW-1:0]         rd_m_i,
    input  logic                      reg_write_m_i,
    input  logic [REG_AW-1:0]         rd_w_i,
    input  logic                      reg_write_w_i,
    input  logic                      pc_src_e_i,
    input  logic                      dmem_busy_i,
    output logic [NUM_SRC*2-1:0]      fwd_sel_o,
    output logic                      stall_f_o,
    output logic                      stall_d_o,
    output logic                      stall_e_o,
    output logic                      stall_m_o,
    output logic                      flush_d_o,
    output logic                      flush_e_o,
    output logic                      flush_w_o
`ifdef HAZARD_PERF_EN
    ,
    output logic [31:0]               stall_cnt_o,
    output logic [31:0]               flush_cnt_o
`endif
);

    localparam int CW = $clog2(LOAD_LAT + 1);

    hz_state_t     state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    fwd_sel_t      sel [NUM_SRC];
    logic          rs_hit;
    logic          lu;

    for (genvar k = 0; k < NUM_SRC; k++) begin : g_fwd
        fwd_select #(
            .REG_AW(REG_AW)
        ) u_fwd (
            .rs_i          (rs_e_i[k*REG_AW +: REG_AW]),
            .rd_m_i        (rd_m_i),
            .reg_write_m_i (reg_write_m_i),
            .rd_w_i        (rd_w_i),
            .reg_write_w_i (reg_write_w_i),
            .sel_o         (sel[k])
        );
        assign fwd_sel_o[k*2 +: 2] = rst_ni ? sel[k] : FWD_RF;
    end

    always_comb begin
        rs_hit = 1'b0;
        for (int k = 0; k < NUM_SRC; k++) begin
            if (rs_d_i[k*REG_AW +: REG_AW] == rd_e_i) begin
                rs_hit = 1'b1;
            end
        end
    end

    assign lu = mem_read_e_i
             && (rd_e_i != REG_AW'(REG_X0))
             && rs_hit;

    // Priority: reset, dmem busy (freeze), branch (squash), load-use FSM.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        stall_f_o = 1'b0;
        stall_d_o = 1'b0;
        stall_e_o = 1'b0;
        stall_m_o = 1'b0;
        flush_d_o = 1'b0;
        flush_e_o = 1'b0;
        flush_w_o = 1'b0;
        if (!rst_ni) begin
            state_d = RUN;
            cnt_d   = '0;
        end else if (dmem_busy_i) begin
            stall_f_o = 1'b1;
            stall_d_o = 1'b1;
            stall_e_o = 1'b1;
            stall_m_o = 1'b1;
            flush_w_o = 1'b1;
        end else if (pc_src_e_i) begin
            flush_d_o = 1'b1;
            flush_e_o = 1'b1;
            state_d   = RUN;
            cnt_d     = '0;
        end else begin
            unique case (state_q)
                RUN: begin
                    if (lu) begin
                        stall_f_o = 1'b1;
                        stall_d_o = 1'b1;
                        flush_e_o = 1'b1;
                        if (LOAD_LAT > 1) begin
                            state_d = LU_STALL;
                            cnt_d   = CW'(LOAD_LAT - 1);
                        end
                    end
                end
                LU_STALL: begin
                    stall_f_o = 1'b1;
                    stall_d_o = 1'b1;
                    flush_e_o = 1'b1;
                    cnt_d     = cnt_q - CW'(1);
                    if (cnt_q == CW'(1)) begin
                        state_d = RUN;
                    end
                end
                default: begin
                    state_d = RUN;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= RUN;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

`ifdef HAZARD_PERF_EN
    logic [31:0] stall_cnt_q;
    logic [31:0] flush_cnt_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            if (stall_d_o) begin
                stall_cnt_q <= stall_cnt_q + 32'd1;
            end
            if (flush_d_o) begin
                flush_cnt_q <= flush_cnt_q + 32'd1;
            end
        end
    end

    assign stall_cnt_o = stall_cnt_q;
    assign flush_cnt_o = flush_cnt_q;
`endif

endmodule

// File: tb/tb_hazard_unit_v2.sv
// Directed bench for hazard_unit_v2 with LOAD_LAT=1 and LOAD_LAT=3 instances.
module tb_hazard_unit_v2;

    localparam int AW = 5;
    localparam int NS = 2;

    localparam logic [6:0] IDLE = 7'b0000000;
    localparam logic [6:0] LU   = 7'b1100010;
    localparam logic [6:0] BR   = 7'b0000110;
    localparam logic [6:0] BUSY = 7'b1111001;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [NS*AW-1:0] rs_d, rs_e;
    logic [AW-1:0]    rd_e, rd_m, rd_w;
    logic             mre, rwm, rww, pcs, busy;
    logic [NS*2-1:0]  fwd1, fwd3;
    wire  [6:0]       c1, c3;

    int n_chk = 0;
    int n_fail = 0;

`ifdef HAZARD_PERF_EN
    logic [31:0] sc1, fc1, sc3, fc3;
`endif

    hazard_unit_v2 #(.REG_AW(AW), .NUM_SRC(NS), .LOAD_LAT(1)) dut1 (
        .clk_i(clk), .rst_ni(rst_n),
        .rs_d_i(rs_d), .rs_e_i(rs_e), .rd_e_i(rd_e),
        .mem_read_e_i(mre), .rd_m_i(rd_m), .reg_write_m_i(rwm),
        .rd_w_i(rd_w), .reg_write_w_i(rww),
        .pc_src_e_i(pcs), .dmem_busy_i(busy),
        .fwd_sel_o(fwd1),
        .stall_f_o(c1[6]), .stall_d_o(c1[5]),
        .stall_e_o(c1[4]), .stall_m_o(c1[3]),
        .flush_d_o(c1[2]), .flush_e_o(c1[1]), .flush_w_o(c1[0])
`ifdef HAZARD_PERF_EN
        , .stall_cnt_o(sc1), .flush_cnt_o(fc1)
`endif
    );

    hazard_unit_v2 #(.REG_AW(AW), .NUM_SRC(NS), .LOAD_LAT(3)) dut3 (
        .clk_i(clk), .rst_ni(rst_n),
        .rs_d_i(rs_d), .rs_e_i(rs_e), .rd_e_i(rd_e),
        .mem_read_e_i(mre), .rd_m_i(rd_m), .reg_write_m_i(rwm),
        .rd_w_i(rd_w), .reg_write_w_i(rww),
        .pc_src_e_i(pcs), .dmem_busy_i(busy),
        .fwd_sel_o(fwd3),
        .stall_f_o(c3[6]), .stall_d_o(c3[5]),
        .stall_e_o(c3[4]), .stall_m_o(c3[3]),
        .flush_d_o(c3[2]), .flush_e_o(c3[1]), .flush_w_o(c3[0])
`ifdef HAZARD_PERF_EN
        , .stall_cnt_o(sc3), .flush_cnt_o(fc3)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        rs_d = '0; rs_e = '0; rd_e = '0; rd_m = '0; rd_w = '0;
        mre = 1'b0; rwm = 1'b0; rww = 1'b0; pcs = 1'b0; busy = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

    initial begin
        idle();
        rs_e = {5'd0, 5'd5}; rd_m = 5'd5; rwm = 1'b1;
        mre = 1'b1; rd_e = 5'd7; rs_d = {5'd7, 5'd0};
        pcs = 1'b1; busy = 1'b1;
        #2;
        chk("rst_ctl3", 32'(c3), 32'(IDLE));
        chk("rst_ctl1", 32'(c1), 32'(IDLE));
        chk("rst_fwd", 32'(fwd3), 32'h0);
        idle();
        cyc(); cyc();
        rst_n = 1'b1;
        cyc();
        chk("idle3", 32'(c3), 32'(IDLE));

        // forwarding
        rs_e = {5'd3, 5'd5}; rd_m = 5'd5; rwm = 1'b1;
        rd_w = 5'd5; rww = 1'b1;
        #1 chk("fwd_m_prio", 32'(fwd3), 32'h2);
        rwm = 1'b0;
        #1 chk("fwd_w", 32'(fwd3), 32'h1);
        rwm = 1'b1; rd_w = 5'd3;
        #1 chk("fwd_mix", 32'(fwd3), 32'h6);
        rd_m = 5'd0; rd_w = 5'd0; rs_e = '0;
        #1 chk("fwd_x0", 32'(fwd3), 32'h0);
        rd_m = 5'd3; rwm = 1'b0; rd_w = 5'd3; rs_e = {5'd3, 5'd3};
        #1 chk("fwd_w_both", 32'(fwd1), 32'h5);
        idle();

        // load-use, LOAD_LAT 1 and 3
        cyc();
        mre = 1'b1; rd_e = 5'd7; rs_d = {5'd7, 5'd2};
        #1 chk("lu1_c1", 32'(c1), 32'(LU));
        chk("lu3_c1", 32'(c3), 32'(LU));
        cyc(); idle();
        #1 chk("lu1_end", 32'(c1), 32'(IDLE));
        chk("lu3_c2", 32'(c3), 32'(LU));
        cyc();
        #1 chk("lu3_c3", 32'(c3), 32'(LU));
        cyc();
        #1 chk("lu3_end", 32'(c3), 32'(IDLE));
        chk("lu1_idle", 32'(c1), 32'(IDLE));
        mre = 1'b1; rd_e = 5'd0; rs_d = '0;
        #1 chk("lu_x0", 32'(c1), 32'(IDLE));
        mre = 1'b0; rd_e = 5'd4; rs_d = {5'd1, 5'd4};
        #1 chk("lu_noload", 32'(c1), 32'(IDLE));
        mre = 1'b1;
        #1 chk("lu_op0", 32'(c1), 32'(LU));
        cyc(); idle();
        #1 chk("lu_op0_end", 32'(c1), 32'(IDLE));
        cyc(); cyc();
        #1 chk("lu3_op0_end", 32'(c3), 32'(IDLE));

        // branch beats load-use
        cyc();
        pcs = 1'b1; mre = 1'b1; rd_e = 5'd7; rs_d = {5'd7, 5'd0};
        #1 chk("br_lu3", 32'(c3), 32'(BR));
        chk("br_lu1", 32'(c1), 32'(BR));
        cyc(); idle();
        #1 chk("br_after3", 32'(c3), 32'(IDLE));
        chk("br_after1", 32'(c1), 32'(IDLE));
        cyc();
        #1 chk("br_nostall", 32'(c3), 32'(IDLE));

        // dmem busy in the middle of a 3-cycle stall
        cyc();
        mre = 1'b1; rd_e = 5'd7; rs_d = {5'd0, 5'd7};
        #1 chk("busy_lu", 32'(c3), 32'(LU));
        cyc(); idle();
        busy = 1'b1; rs_e = {5'd0, 5'd5}; rd_m = 5'd5; rwm = 1'b1;
        #1 chk("busy_c1", 32'(c3), 32'(BUSY));
        chk("busy_fwd", 32'(fwd3), 32'h2);
        chk("busy_dut1", 32'(c1), 32'(BUSY));
        for (int i = 0; i < 3; i++) begin
            cyc();
            #1 chk("busy_hold", 32'(c3), 32'(BUSY));
        end
        cyc();
        busy = 1'b0; rwm = 1'b0;
        #1 chk("resume1", 32'(c3), 32'(LU));
        cyc();
        #1 chk("resume2", 32'(c3), 32'(LU));
        cyc();
        #1 chk("resume_end", 32'(c3), 32'(IDLE));
        busy = 1'b1; pcs = 1'b1;
        #1 chk("busy_br", 32'(c3), 32'(BUSY));
        cyc();
        busy = 1'b0;
        #1 chk("br_after_busy", 32'(c3), 32'(BR));
        idle();

        // asynchronous reset during LU_STALL
        cyc();
        mre = 1'b1; rd_e = 5'd7; rs_d = {5'd7, 5'd0};
        #1 chk("rst_lu", 32'(c3), 32'(LU));
        cyc();
        mre = 1'b0; rs_e = {5'd0, 5'd5}; rd_m = 5'd5; rwm = 1'b1;
        #1 chk("pre_rst", 32'(c3), 32'(LU));
        chk("pre_rst_fwd", 32'(fwd3), 32'h2);
        #2 rst_n = 1'b0;
        #1 chk("async_rst", 32'(c3), 32'(IDLE));
        chk("async_fwd", 32'(fwd3), 32'h0);
        idle();
        cyc();
        #2 rst_n = 1'b1;
        cyc();
        #1 chk("post_rst1", 32'(c3), 32'(IDLE));
        cyc();
        #1 chk("post_rst2", 32'(c3), 32'(IDLE));
        cyc();
        #1 chk("post_rst3", 32'(c3), 32'(IDLE));

`ifdef HAZARD_PERF_EN
        chk("perf_rst_s", sc3, 32'd0);
        chk("perf_rst_f", fc3, 32'd0);
        busy = 1'b1;
        for (int i = 0; i < 9; i++) cyc();
        cyc();
        busy = 1'b0;
        #1 chk("perf_stall10", sc3, 32'd10);
        pcs = 1'b1;
        cyc(); cyc(); cyc();
        pcs = 1'b0;
        #1 chk("perf_flush3", fc3, 32'd3);
        chk("perf_stall_keep", sc3, 32'd10);
        dut3.stall_cnt_q = 32'hFFFF_FFFF;
        busy = 1'b1;
        cyc();
        busy = 1'b0;
        #1 chk("perf_wrap", sc3, 32'd0);
`endif

        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end

endmodule
